// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the instruction sequencer: state encoding and the
// alu memory-mode codes the sequencer decodes.
package cpu_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_REGREAD = 4'd3,
      ST_EXEC    = 4'd4,
      ST_RESOLVE = 4'd5,
      ST_MEM     = 4'd6,
      ST_WB      = 4'd7,
      ST_HALT    = 4'd8
   } state_e;

   typedef logic [1:0] mem_mode_t;

   localparam mem_mode_t MODE_NOP     = 2'd0;
   localparam mem_mode_t MODE_READ    = 2'd1;
   localparam mem_mode_t MODE_WRITE   = 2'd2;
   localparam mem_mode_t MODE_ILLEGAL = 2'd3;

   function automatic logic is_mem_access(input mem_mode_t mode);
      return (mode == MODE_READ) || (mode == MODE_WRITE);
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Handshake and strobe bundle between the sequencer and the CPU datapath.
// master = sequencer side, slave = memories/decoder/regfile/alu/PC side.
interface cpu_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             I_imem_ready;
   logic             I_dmem_ready;
   logic             I_alu_write_rD;
   logic             I_alu_write_pc;
   logic [1:0]       I_alu_memory_mode;
   logic             I_halt;
   logic             O_imem_req;
   logic             O_decode_en;
   logic             O_reg_en;
   logic             O_alu_en;
   logic             O_dmem_req;
   logic             O_dmem_we;
   logic             O_rd_write;
   logic             O_pc_write;
   logic             O_pc_inc;
   logic [CNT_W-1:0] O_retired;
   logic             O_error;
   logic             O_halted;

   modport master (
      input  I_imem_ready, I_dmem_ready, I_alu_write_rD, I_alu_write_pc,
             I_alu_memory_mode, I_halt,
      output O_imem_req, O_decode_en, O_reg_en, O_alu_en, O_dmem_req,
             O_dmem_we, O_rd_write, O_pc_write, O_pc_inc, O_retired,
             O_error, O_halted
   );

   modport slave (
      output I_imem_ready, I_dmem_ready, I_alu_write_rD, I_alu_write_pc,
             I_alu_memory_mode, I_halt,
      input  O_imem_req, O_decode_en, O_reg_en, O_alu_en, O_dmem_req,
             O_dmem_we, O_rd_write, O_pc_write, O_pc_inc, O_retired,
             O_error, O_halted
   );

endinterface

// File: rtl/cpu_sequencer_seq_timer.sv
// Loadable, clearable up-counter with a terminal-count flag, used to bound
// the number of cycles spent waiting on data memory.
module seq_timer #(
   parameter int         W        = 8,
   parameter logic [W-1:0] TC_VALUE = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic         tc
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (inc) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // tc is high during the cycle whose count equals TC_VALUE.
   assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, regread, exec, resolve,
// optional data access, writeback. Outputs depend only on registered state.
module cpu_sequencer #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input logic            I_clk,
   input logic            I_reset,
   cpu_sequencer_if.master bus
);
   import cpu_sequencer_pkg::*;

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic             wr_rd_q, wr_rd_d;
   logic             wr_pc_q, wr_pc_d;
   mem_mode_t        mode_q, mode_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic timer_load;
   logic timer_inc;
   logic timer_tc;

   seq_timer #(
      .W        (TW),
      .TC_VALUE (TIMER_TC)
   ) u_timer (
      .clk      (I_clk),
      .srst     (I_reset),
      .load     (timer_load),
      .load_val ('0),
      .inc      (timer_inc),
      .tc       (timer_tc)
   );

   always_comb begin
      state_d    = state_q;
      wr_rd_d    = wr_rd_q;
      wr_pc_d    = wr_pc_q;
      mode_d     = mode_q;
      error_d    = error_q;
      retired_d  = retired_q;
      timer_load = 1'b0;
      timer_inc  = 1'b0;

      case (state_q)
         ST_IDLE:    state_d = ST_FETCH;
         ST_FETCH: begin
            if (bus.I_imem_ready) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE:  state_d = ST_REGREAD;
         ST_REGREAD: state_d = ST_EXEC;
         ST_EXEC:    state_d = ST_RESOLVE;
         ST_RESOLVE: begin
            // alu outputs are registered, so they are only trustworthy here.
            wr_rd_d    = bus.I_alu_write_rD;
            wr_pc_d    = bus.I_alu_write_pc;
            timer_load = 1'b1;
            if (is_mem_access(bus.I_alu_memory_mode)) begin
               mode_d  = bus.I_alu_memory_mode;
               state_d = ST_MEM;
            end else begin
               mode_d  = MODE_NOP;
               state_d = ST_WB;
               if (bus.I_alu_memory_mode == MODE_ILLEGAL) begin
                  error_d = 1'b1;
               end
            end
         end
         ST_MEM: begin
            timer_inc = 1'b1;
            if (bus.I_dmem_ready) begin
               state_d = ST_WB;
            end else if (timer_tc) begin
               // Aborted access: never commit a register write from it.
               error_d = 1'b1;
               wr_rd_d = 1'b0;
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = bus.I_halt ? ST_HALT : ST_FETCH;
         end
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state_q   <= ST_IDLE;
         wr_rd_q   <= 1'b0;
         wr_pc_q   <= 1'b0;
         mode_q    <= MODE_NOP;
         error_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_rd_q   <= wr_rd_d;
         wr_pc_q   <= wr_pc_d;
         mode_q    <= mode_d;
         error_q   <= error_d;
         retired_q <= retired_d;
      end
   end

   assign bus.O_imem_req  = (state_q == ST_FETCH);
   assign bus.O_decode_en = (state_q == ST_DECODE);
   assign bus.O_reg_en    = (state_q == ST_REGREAD);
   assign bus.O_alu_en    = (state_q == ST_EXEC);
   assign bus.O_dmem_req  = (state_q == ST_MEM);
   assign bus.O_dmem_we   = (state_q == ST_MEM) && (mode_q == MODE_WRITE);
   assign bus.O_rd_write  = (state_q == ST_WB) && wr_rd_q && (mode_q != MODE_WRITE);
   assign bus.O_pc_write  = (state_q == ST_WB) && wr_pc_q;
   assign bus.O_pc_inc    = (state_q == ST_WB) && !wr_pc_q;
   assign bus.O_retired   = retired_q;
   assign bus.O_error     = error_q;
   assign bus.O_halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table, hand-written reset
// and wrap sequences, then randomized instructions against a schedule model.
module tb_cpu_sequencer;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;

   localparam logic [9:0] V_IMEM = 10'h200;
   localparam logic [9:0] V_DEC  = 10'h100;
   localparam logic [9:0] V_REG  = 10'h080;
   localparam logic [9:0] V_ALU  = 10'h040;
   localparam logic [9:0] V_DMEM = 10'h020;
   localparam logic [9:0] V_WE   = 10'h010;
   localparam logic [9:0] V_RDW  = 10'h008;
   localparam logic [9:0] V_PCW  = 10'h004;
   localparam logic [9:0] V_PCI  = 10'h002;
   localparam logic [9:0] V_HALT = 10'h001;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

   cpu_sequencer #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .I_clk   (clk),
      .I_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int exp_retired = 0;
   bit exp_err = 1'b0;

   typedef struct {
      int iw; bit wrd; bit wpc; int mode; int dw; bit halt;
      int len; bit rdw; bit pcw; bit err;
   } vec_t;

   function automatic logic [9:0] outs();
      return {bus.O_imem_req, bus.O_decode_en, bus.O_reg_en, bus.O_alu_en,
              bus.O_dmem_req, bus.O_dmem_we, bus.O_rd_write, bus.O_pc_write,
              bus.O_pc_inc, bus.O_halted};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cycle(input string name, input logic [9:0] e_o, input bit e_err);
      chk({name, " outs"}, int'(outs()), int'(e_o));
      chk({name, " err"}, int'(bus.O_error), int'(e_err));
      chk({name, " retired"}, int'(bus.O_retired), exp_retired);
   endtask

   task automatic noise();
      bus.I_imem_ready      = 1'($urandom_range(0, 1));
      bus.I_dmem_ready      = 1'($urandom_range(0, 1));
      bus.I_alu_write_rD    = 1'($urandom_range(0, 1));
      bus.I_alu_write_pc    = 1'($urandom_range(0, 1));
      bus.I_alu_memory_mode = 2'($urandom_range(0, 3));
      bus.I_halt            = 1'($urandom_range(0, 1));
   endtask

   // Expected per-cycle strobes come from the instruction's stage schedule:
   // iw fetch waits, fixed decode/regread/exec/resolve, bounded data access, WB.
   task automatic run_instr(input int iw, input bit wrd, input bit wpc, input int mode,
                            input int dw, input bit halt,
                            output int obs_len, output bit obs_rd, output bit obs_pc);
      bit is_mem;
      int n_mem;
      bit tmo;
      int len;
      is_mem  = (mode == 1) || (mode == 2);
      n_mem   = is_mem ? ((dw + 1 < TIMEOUT) ? dw + 1 : TIMEOUT) : 0;
      tmo     = is_mem && (dw >= TIMEOUT);
      len     = iw + 6 + n_mem;
      obs_len = -1;
      obs_rd  = 1'b0;
      obs_pc  = 1'b0;
      for (int c = 0; c < len; c++) begin
         logic [9:0] e;
         bit ee;
         if (c <= iw)          e = V_IMEM;
         else if (c == iw + 1) e = V_DEC;
         else if (c == iw + 2) e = V_REG;
         else if (c == iw + 3) e = V_ALU;
         else if (c == iw + 4) e = '0;
         else if (c < len - 1) e = V_DMEM | ((mode == 2) ? V_WE : 10'h0);
         else e = ((wrd && mode != 2 && !tmo) ? V_RDW : 10'h0) | (wpc ? V_PCW : V_PCI);
         ee = exp_err | ((mode == 3) && (c > iw + 4)) | (tmo && (c >= len - 1));
         check_cycle($sformatf("instr c%0d", c), e, ee);
         if (obs_len < 0 && (bus.O_pc_write || bus.O_pc_inc)) begin
            obs_len = c + 1;
            obs_rd  = bus.O_rd_write;
            obs_pc  = bus.O_pc_write;
         end
         noise();
         if (c <= iw) bus.I_imem_ready = (c == iw);
         if (c == iw + 4) begin
            bus.I_alu_write_rD    = wrd;
            bus.I_alu_write_pc    = wpc;
            bus.I_alu_memory_mode = 2'(mode);
         end
         if (c >= iw + 5 && c < len - 1) bus.I_dmem_ready = (c == iw + 5 + dw);
         if (c == len - 1) bus.I_halt = halt;
         tick();
      end
      exp_err     = exp_err | (mode == 3) | tmo;
      exp_retired = (exp_retired + 1) % (1 << CNT_W);
   endtask

   // Leaves the DUT in FETCH after checking the all-zero IDLE cycle.
   task automatic do_reset(input string name);
      rst = 1'b1;
      noise();
      tick();
      exp_retired = 0;
      exp_err     = 1'b0;
      check_cycle(name, 10'h0, 1'b0);
      rst = 1'b0;
      noise();
      tick();
   endtask

   vec_t tbl[7];
   int   o_len;
   bit   o_rd, o_pc;

   initial begin
      tbl[0] = '{iw:0, wrd:1, wpc:0, mode:0, dw:0, halt:0, len:6,  rdw:1, pcw:0, err:0};
      tbl[1] = '{iw:0, wrd:0, wpc:1, mode:0, dw:0, halt:0, len:6,  rdw:0, pcw:1, err:0};
      tbl[2] = '{iw:0, wrd:1, wpc:0, mode:2, dw:3, halt:0, len:10, rdw:0, pcw:0, err:0};
      tbl[3] = '{iw:2, wrd:1, wpc:0, mode:1, dw:0, halt:0, len:9,  rdw:1, pcw:0, err:0};
      tbl[4] = '{iw:0, wrd:1, wpc:0, mode:1, dw:9, halt:0, len:10, rdw:0, pcw:0, err:1};
      tbl[5] = '{iw:1, wrd:1, wpc:0, mode:0, dw:0, halt:0, len:7,  rdw:1, pcw:0, err:1};
      tbl[6] = '{iw:0, wrd:1, wpc:0, mode:3, dw:0, halt:1, len:6,  rdw:1, pcw:0, err:1};

      rst = 1'b1;
      noise();
      tick();
      do_reset("reset initial");

      foreach (tbl[i]) begin
         run_instr(tbl[i].iw, tbl[i].wrd, tbl[i].wpc, tbl[i].mode, tbl[i].dw, tbl[i].halt,
                   o_len, o_rd, o_pc);
         chk($sformatf("vec%0d len", i), o_len, tbl[i].len);
         chk($sformatf("vec%0d rd_write", i), int'(o_rd), int'(tbl[i].rdw));
         chk($sformatf("vec%0d pc_write", i), int'(o_pc), int'(tbl[i].pcw));
         chk($sformatf("vec%0d error", i), int'(bus.O_error), int'(tbl[i].err));
      end

      for (int k = 0; k < 20; k++) begin
         check_cycle($sformatf("halt hold %0d", k), V_HALT, 1'b1);
         noise();
         tick();
      end
      chk("halt retired", int'(bus.O_retired), 7);
      do_reset("reset from halt");

      // Reset in the middle of a data access.
      run_instr(0, 1, 0, 0, 0, 0, o_len, o_rd, o_pc);
      bus.I_imem_ready      = 1'b1;
      bus.I_dmem_ready      = 1'b0;
      bus.I_alu_write_rD    = 1'b1;
      bus.I_alu_write_pc    = 1'b0;
      bus.I_alu_memory_mode = 2'd1;
      bus.I_halt            = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("mid mem dmem_req", int'(bus.O_dmem_req), 1);
      chk("mid mem retired", int'(bus.O_retired), 1);
      do_reset("reset mid mem");

      // Reset while fetch is stalled.
      bus.I_imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("mid fetch imem_req", int'(bus.O_imem_req), 1);
      do_reset("reset mid fetch");

      for (int k = 0; k < 16; k++) run_instr(0, 1, 0, 0, 0, 0, o_len, o_rd, o_pc);
      chk("retired wrap", int'(bus.O_retired), 0);

      for (int k = 0; k < 60; k++) begin
         run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 6), 1'b0, o_len, o_rd, o_pc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
